// File: rtl/stream_frame_engine.sv
// stream_frame_engine: capture one AXI-Stream frame, transform each beat in place, replay it.
// Optional STREAM_FRAME_SAT_EN: saturating adds plus a sticky sat_hit output.
module stream_frame_engine #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int BRAM_AW    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [BRAM_AW-1:0]    bram_addrb,
    output logic                  bram_enb,
    input  logic [DATA_WIDTH-1:0] bram_doutb,
    input  logic [1:0]            cfg_mode,
    input  logic [DATA_WIDTH-1:0] cfg_offset,
    input  logic [BRAM_AW-1:0]    cfg_coef_base,
    output logic                  busy,
    output logic [ADDR_W:0]       frame_len,
    output logic                  overflow,
    output logic                  frame_done
`ifdef STREAM_FRAME_SAT_EN
    ,
    output logic                  sat_hit
`endif
);
    typedef enum logic [1:0] {RECV, PROC, SEND} state_t;
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

    state_t state_q, state_d;
    logic [ADDR_W:0] cnt_q, cnt_d, ptr_q, ptr_d, len_q, len_d;
    logic [1:0] mode_q, mode_d;
    logic [DATA_WIDTH-1:0] offset_q, offset_d, md_q, md_d, rd_data_q;
    logic [BRAM_AW-1:0] base_q, base_d;
    logic tready_q, tready_d, ovf_q, ovf_d;
    logic rv_q, rv_d, rlast_q, rlast_d, mv_q, mv_d, ml_q, ml_d;
    logic we, re, out_ready, rd_ready;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [DATA_WIDTH-1:0] wdata, opnd, res;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign opnd = (mode_q == 2'd0) ? offset_q : (mode_q == 2'd1) ? bram_doutb : '0;
`ifdef STREAM_FRAME_SAT_EN
    logic sat_q, sat_d;
    logic [DATA_WIDTH:0] sum;
    assign sum     = {1'b0, rd_data_q} + {1'b0, opnd};
    assign res     = sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
    assign sat_hit = sat_q;
`else
    assign res = rd_data_q + opnd;
`endif

    assign out_ready     = !mv_q || m_axis_tready;
    assign rd_ready      = !rv_q || out_ready;
    assign s_axis_tready = tready_q;
    assign m_axis_tdata  = md_q;
    assign m_axis_tvalid = mv_q;
    assign m_axis_tlast  = ml_q;
    assign frame_len     = len_q;
    assign overflow      = ovf_q;
    assign busy          = (state_q != RECV) || (cnt_q != '0);
    assign bram_addrb    = bram_enb ? base_q + BRAM_AW'(ptr_q) * BRAM_AW'(DATA_WIDTH/8) : '0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        mode_d     = mode_q;
        offset_d   = offset_q;
        base_d     = base_q;
        ovf_d      = ovf_q;
        tready_d   = 1'b0;
        rv_d       = rv_q;
        rlast_d    = rlast_q;
        mv_d       = mv_q;
        md_d       = md_q;
        ml_d       = ml_q;
        we         = 1'b0;
        waddr      = cnt_q[ADDR_W-1:0];
        wdata      = s_axis_tdata;
        re         = 1'b0;
        raddr      = ptr_q[ADDR_W-1:0];
        bram_enb   = 1'b0;
        frame_done = 1'b0;
`ifdef STREAM_FRAME_SAT_EN
        sat_d      = sat_q;
`endif
        case (state_q)
            RECV: begin
                tready_d = 1'b1;
                if (s_axis_tvalid && tready_q) begin
                    if (cnt_q == '0) begin
                        mode_d   = cfg_mode;
                        offset_d = cfg_offset;
                        base_d   = cfg_coef_base;
`ifdef STREAM_FRAME_SAT_EN
                        sat_d    = 1'b0;
`endif
                    end
                    // Beats past DEPTH are swallowed so the upstream frame still drains.
                    if (cnt_q != FULL) begin
                        we    = 1'b1;
                        cnt_d = cnt_q + ONE;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (s_axis_tlast) begin
                        len_d    = cnt_d;
                        ptr_d    = '0;
                        tready_d = 1'b0;
                        state_d  = PROC;
                    end
                end
            end
            PROC: begin
                re       = ptr_q < len_q;
                bram_enb = re && (mode_q == 2'd1);
                if (ptr_q != '0) begin
                    we    = 1'b1;
                    waddr = ADDR_W'(ptr_q - ONE);
                    wdata = res;
`ifdef STREAM_FRAME_SAT_EN
                    sat_d = sat_q | sum[DATA_WIDTH];
`endif
                end
                ptr_d = ptr_q + ONE;
                if (ptr_q == len_q) begin
                    ptr_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    mv_d = rv_q;
                    md_d = rd_data_q;
                    ml_d = rv_q && rlast_q;
                end
                // Read stage refills whenever it is empty or draining into the output register.
                if (rd_ready) begin
                    re      = ptr_q < len_q;
                    rv_d    = re;
                    rlast_d = ptr_q == len_q - ONE;
                    if (re) ptr_d = ptr_q + ONE;
                end
                if (mv_q && m_axis_tready && ml_q) begin
                    frame_done = 1'b1;
                    cnt_d      = '0;
                    ptr_d      = '0;
                    mv_d       = 1'b0;
                    ml_d       = 1'b0;
                    rv_d       = 1'b0;
                    tready_d   = 1'b1;
                    state_d    = RECV;
                end
            end
            default: state_d = RECV;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rd_data_q <= mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RECV;
            cnt_q    <= '0;
            ptr_q    <= '0;
            len_q    <= '0;
            mode_q   <= '0;
            offset_q <= '0;
            base_q   <= '0;
            ovf_q    <= 1'b0;
            tready_q <= 1'b0;
            rv_q     <= 1'b0;
            rlast_q  <= 1'b0;
            mv_q     <= 1'b0;
            md_q     <= '0;
            ml_q     <= 1'b0;
`ifdef STREAM_FRAME_SAT_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            len_q    <= len_d;
            mode_q   <= mode_d;
            offset_q <= offset_d;
            base_q   <= base_d;
            ovf_q    <= ovf_d;
            tready_q <= tready_d;
            rv_q     <= rv_d;
            rlast_q  <= rlast_d;
            mv_q     <= mv_d;
            md_q     <= md_d;
            ml_q     <= ml_d;
`ifdef STREAM_FRAME_SAT_EN
            sat_q    <= sat_d;
`endif
        end
    end
endmodule
